// File: rtl/shift_pkg.sv
// shift_pkg: shared mode codes and FSM state encoding for univ_shift_reg.
//   MODE_* : 3-bit operation selector values for i_MODE
//   state_t: IDLE / XFER states of the automatic serial transfer
package shift_pkg;
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;
endpackage

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal WIDTH-bit register with hold/load/shift/rotate/clear
// modes and an automatic MSB-first serial transfer of WIDTH bits.
//   i_CLK, i_RST : clock, synchronous active-high reset
//   i_EN         : enable for mode operations and transfer shifts (baud tick)
//   i_MODE       : operation select, honoured in IDLE only
//   i_D, i_SER   : parallel and serial data in
//   i_START      : begin a transfer (IDLE only, independent of i_EN)
//   o_Q          : register contents
//   o_SER_OUT    : serial out, always o_Q[WIDTH-1]
//   o_BUSY       : transfer in progress
//   o_DONE       : one-cycle pulse after the last transfer shift
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_EN,
    input  logic [2:0]       i_MODE,
    input  logic [WIDTH-1:0] i_D,
    input  logic             i_SER,
    input  logic             i_START,
    output logic [WIDTH-1:0] o_Q,
    output logic             o_SER_OUT,
    output logic             o_BUSY,
    output logic             o_DONE
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic             r_busy;
    logic             w_busy_next;
    logic             r_done;
    logic             w_done_next;

    assign o_Q       = r_q;
    assign o_SER_OUT = r_q[WIDTH-1];
    assign o_BUSY    = r_busy;
    assign o_DONE    = r_done;

    // Next-Q mux: START beats MODE in IDLE; XFER always shifts left on i_EN.
    always_comb begin
        w_q_next = r_q;
        if (r_state == ST_IDLE) begin
            if (i_START) begin
                w_q_next = i_D;
            end else if (i_EN) begin
                case (i_MODE)
                    MODE_HOLD: w_q_next = r_q;
                    MODE_LOAD: w_q_next = i_D;
                    MODE_SHL:  w_q_next = {r_q[WIDTH-2:0], i_SER};
                    MODE_SHR:  w_q_next = {i_SER, r_q[WIDTH-1:1]};
                    MODE_ROL:  w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    MODE_ROR:  w_q_next = {r_q[0], r_q[WIDTH-1:1]};
                    MODE_ASR:  w_q_next = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                    default:   w_q_next = '0;
                endcase
            end
        end else if (i_EN) begin
            w_q_next = {r_q[WIDTH-2:0], i_SER};
        end
    end

    // Transfer FSM: counter counts completed shifts; the WIDTH-th ends XFER.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_START) begin
                    w_state_next = ST_XFER;
                    w_cnt_next   = '0;
                    w_busy_next  = 1'b1;
                end
            end
            default: begin
                if (i_EN) begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (w_cnt_next == CNT_LAST) begin
                        w_state_next = ST_IDLE;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_q     <= '0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_q     <= w_q_next;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed self-checking bench for univ_shift_reg (WIDTH=8).
module tb_univ_shift_reg;
    import shift_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = MODE_HOLD;
    logic [7:0] d = 8'h00;
    logic       ser_drv = 1'b0;
    logic       loopback = 1'b0;
    logic       start = 1'b0;
    logic [7:0] q;
    logic       ser_out;
    logic       busy;
    logic       done;
    logic       ser;

    int checks = 0;
    int errors = 0;

    assign ser = loopback ? ser_out : ser_drv;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8)) dut (
        .i_CLK(clk),
        .i_RST(rst),
        .i_EN(en),
        .i_MODE(mode),
        .i_D(d),
        .i_SER(ser),
        .i_START(start),
        .o_Q(q),
        .o_SER_OUT(ser_out),
        .o_BUSY(busy),
        .o_DONE(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        mode = MODE_LOAD; d = v; en = 1'b1;
        tick();
        en = 1'b0; mode = MODE_HOLD;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: q=%h busy=%b done=%b, want q=00 busy=0 done=0", q, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_load_hold();
        load(8'hA5);
        checks++;
        if (q !== 8'hA5) begin errors++; $display("FAIL load: q=%h want a5", q); end
        mode = MODE_HOLD; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q !== 8'hA5) begin errors++; $display("FAIL hold[%0d]: q=%h want a5", i, q); end
        end
        mode = MODE_LOAD; d = 8'h00; en = 1'b0;
        tick();
        checks++;
        if (q !== 8'hA5) begin errors++; $display("FAIL en_low: q=%h want a5", q); end
        mode = MODE_HOLD;
    endtask

    task automatic test_modes();
        logic [2:0] m_tab [8] = '{MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR, MODE_CLR, MODE_ROR, MODE_ASR};
        logic       s_tab [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] i_tab [8] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h96, 8'h96};
        logic [7:0] e_tab [8] = '{8'h02, 8'hC0, 8'h03, 8'hC0, 8'hC0, 8'h00, 8'h4B, 8'hCB};
        for (int i = 0; i < 8; i++) begin
            load(i_tab[i]);
            mode = m_tab[i]; ser_drv = s_tab[i]; en = 1'b1;
            tick();
            en = 1'b0;
            checks++;
            if (q !== e_tab[i] || ser_out !== e_tab[i][7]) begin
                errors++;
                $display("FAIL mode[%0d] m=%b: q=%h ser_out=%b want q=%h", i, m_tab[i], q, ser_out, e_tab[i]);
            end
        end
        mode = MODE_HOLD; ser_drv = 1'b0;
    endtask

    task automatic test_xfer();
        logic [7:0] pat = 8'hB4;
        int busy_cnt = 0;
        loopback = 1'b1; d = pat; start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            busy_cnt += int'(busy);
            checks++;
            if (ser_out !== pat[7-i] || done !== 1'b0) begin
                errors++;
                $display("FAIL xfer_bit[%0d]: ser_out=%b done=%b want ser_out=%b done=0", i, ser_out, done, pat[7-i]);
            end
            tick();
        end
        checks++;
        if (busy_cnt != 8 || busy !== 1'b0 || done !== 1'b1 || q !== pat) begin
            errors++;
            $display("FAIL xfer_end: busy_cycles=%0d busy=%b done=%b q=%h want 8 0 1 b4", busy_cnt, busy, done, q);
        end
        en = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL xfer_done_pulse: done=%b want 0", done); end
        loopback = 1'b0;
    endtask

    task automatic test_xfer_stall();
        logic [7:0] pat = 8'hB4;
        int busy_cnt = 0;
        int done_cnt = 0;
        loopback = 1'b1; d = pat; start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            en = k[0];
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            checks++;
            if (ser_out !== pat[7-k/2] || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_bit[%0d]: ser_out=%b busy=%b want ser_out=%b busy=1", k, ser_out, busy, pat[7-k/2]);
            end
            tick();
        end
        en = 1'b0;
        done_cnt += int'(done);
        checks++;
        if (busy_cnt != 16 || busy !== 1'b0 || done !== 1'b1 || q !== pat) begin
            errors++;
            $display("FAIL stall_end: busy_cycles=%0d busy=%b done=%b q=%h want 16 0 1 b4", busy_cnt, busy, done, q);
        end
        tick();
        done_cnt += int'(done);
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL stall_done_count: %0d want 1", done_cnt); end
        loopback = 1'b0;
    endtask

    task automatic test_reset_abort();
        int done_cnt = 0;
        loopback = 1'b1; d = 8'hB4; start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort: q=%h busy=%b done=%b want 00 0 0", q, busy, done);
        end
        mode = MODE_HOLD;
        for (int i = 0; i < 10; i++) begin
            tick();
            done_cnt += int'(done | busy);
        end
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL abort_quiet: done/busy cycles=%0d want 0", done_cnt); end
        loopback = 1'b0;
        load(8'h3C);
        checks++;
        if (q !== 8'h3C) begin errors++; $display("FAIL abort_reload: q=%h want 3c", q); end
    endtask

    task automatic test_back_to_back();
        int done_cnt = 0;
        loopback = 1'b1; mode = MODE_CLR; d = 8'h5A; start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (q !== 8'h5A || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_vs_clr: q=%h busy=%b want 5a 1", q, busy);
        end
        for (int i = 0; i < 8; i++) begin
            start = (i == 3); d = 8'hFF;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL start_ignored[%0d]: busy=%b done=%b want 1 0", i, busy, done);
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || q !== 8'h5A) begin
            errors++;
            $display("FAIL b2b_end: busy=%b done=%b q=%h want 0 1 5a", busy, done, q);
        end
        d = 8'h81; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || q !== 8'h81) begin
            errors++;
            $display("FAIL restart_in_done: busy=%b done=%b q=%h want 1 0 81", busy, done, q);
        end
        for (int i = 0; i < 12 && !done; i++) tick();
        done_cnt = int'(done);
        checks++;
        if (done_cnt != 1 || q !== 8'h81) begin
            errors++;
            $display("FAIL restart_end: done=%0d q=%h want 1 81", done_cnt, q);
        end
        loopback = 1'b0; en = 1'b0; mode = MODE_HOLD;
    endtask

    initial begin
        test_reset();
        test_load_hold();
        test_modes();
        test_xfer();
        test_xfer_stall();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal register, successor to the team's fixed 8-bit button-loaded parallel register. Supports hold, parallel load, shift/rotate and clear modes, plus an automatic WIDTH-bit serial transfer sequence with busy/done flags. Sits between switch/bus inputs and serial links or display logic in board-level designs.

Parameters:
WIDTH, 8, register width in bits; legal range WIDTH >= 2.

Ports:
i_CLK  in  1  system clock; all state updates on the rising edge.
i_RST  in  1  synchronous, active-high reset.
i_EN  in  1  clock enable for mode operations and transfer shifts.
i_MODE  in  3  operation selector, used in IDLE only.
i_D  in  WIDTH  parallel data in.
i_SER  in  1  serial data in.
i_START  in  1  starts an automatic transfer.
o_Q  out  WIDTH  register contents.
o_SER_OUT  out  1  serial out; combinational, equals o_Q[WIDTH-1].
o_BUSY  out  1  high while a transfer is in progress.
o_DONE  out  1  single-cycle pulse when a transfer completes.

Behaviour:
- Reset: o_Q=0, state=IDLE, counter=0, o_BUSY=0, o_DONE=0. Reset overrides everything, including an in-progress transfer, which is aborted with no o_DONE.
- States: IDLE and XFER. All outputs except o_SER_OUT are registered.
- In IDLE with i_START=0 and i_EN=1, i_MODE selects the operation:
  - 000 HOLD
  - 001 LOAD: Q=i_D
  - 010 SHL: Q={Q[W-2:0],i_SER}
  - 011 SHR: Q={i_SER,Q[W-1:1]}
  - 100 ROL
  - 101 ROR
  - 110 ASR: Q={Q[W-1],Q[W-1:1]}
  - 111 CLR: Q=0
- In IDLE with i_EN=0 and i_START=0: Q holds.
- i_START in IDLE is sampled regardless of i_EN and takes priority over i_MODE.
  - At that edge: Q=i_D, counter=0, state=XFER, o_BUSY=1.
- In XFER:
  - i_MODE and i_START are ignored.
  - On each edge with i_EN=1: Q={Q[W-2:0],i_SER} (MSB first out) and counter increments.
  - With i_EN=0, Q and counter hold; i_EN acts as a baud-tick stall.
- Completion: on the edge performing the WIDTH-th shift:
  - state goes to IDLE, o_BUSY=0, o_DONE=1 for exactly one cycle.
  - Q then holds the WIDTH received bits; the first received bit is at the MSB.
- Latency: with i_EN held high, the START edge is followed by WIDTH shift edges. o_BUSY is high for WIDTH cycles, and o_DONE is asserted in the cycle after the last shift.
- A new i_START in the o_DONE cycle is accepted, since the state is IDLE.
- Counter width is $clog2(WIDTH+1). The counter never wraps, because it is cleared at each start.

Decomposition:
- Package shift_pkg holds:
  - 3-bit mode localparams: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR, MODE_CLR.
  - State encoding: ST_IDLE, ST_XFER.
- Single module; no sub-module is warranted. The next-Q mux and the FSM/counter are separate always blocks in the same file.

Test Plan:
- Reset, then LOAD i_D=0xA5 with i_EN=1 -> o_Q=0xA5 next cycle; HOLD for 3 cycles -> 0xA5 unchanged; i_EN=0 with LOAD 0x00 -> o_Q stays 0xA5.
- From o_Q=0x81 (reloaded before each op): SHL i_SER=0 -> 0x02; SHR i_SER=1 -> 0xC0; ROL -> 0x03; ROR -> 0xC0; ASR -> 0xC0; CLR -> 0x00. From 0x96: ROR -> 0x4B, ASR -> 0xCB.
- i_START with i_D=0xB4, i_EN=1, i_SER looped back from o_SER_OUT -> o_SER_OUT sequence 1,0,1,1,0,1,0,0; o_BUSY high 8 cycles; o_DONE pulses once; final o_Q=0xB4.
- Same transfer with i_EN toggling 1,0,1,0,... -> o_BUSY high 16 cycles, identical bit sequence; o_DONE still a single cycle.
- i_RST asserted after 3 shifts of a transfer -> next cycle o_Q=0, o_BUSY=0, o_DONE never asserted; subsequent LOAD 0x3C works.
- i_START together with MODE_CLR in IDLE -> load of i_D wins and the transfer starts; i_START pulsed during o_BUSY -> ignored, completion timing unchanged.
